// File: rtl/stream_comparator.sv
// stream_comparator: two-stage pipelined multi-lane comparator with valid/ready
// handshaking, per-beat relation select, any/all flags and a saturating count
// of matching lanes.
// Optional feature macro: STREAM_COMPARATOR_SIGNED_EN enables two's-complement
// lane compares when signed_mode=1; without it every compare is unsigned.
module stream_comparator #(
    parameter int BITS  = 8,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*BITS-1:0] a,
    input  logic [LANES*BITS-1:0] b,
    input  logic [2:0]            op,
    input  logic                  signed_mode,
    input  logic                  clear,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES-1:0]      result,
    output logic                  any_match,
    output logic                  all_match,
    output logic [CNT_W-1:0]      match_cnt
);

    localparam int PW = $clog2(LANES + 1);
    localparam int SW = CNT_W + 1;

    typedef enum logic [2:0] {
        OP_EQ  = 3'd0,
        OP_NEQ = 3'd1,
        OP_LT  = 3'd2,
        OP_LTE = 3'd3,
        OP_GT  = 3'd4,
        OP_GTE = 3'd5
    } op_t;

    logic                  ready_en;
    logic                  s1_valid;
    logic [LANES*BITS-1:0] s1_a;
    logic [LANES*BITS-1:0] s1_b;
    logic [2:0]            s1_op;
    logic                  s1_signed;
    logic                  s1_load;
    logic                  s2_load;
    logic [LANES-1:0]      cmp;
    logic [BITS-1:0]       lane_a;
    logic [BITS-1:0]       lane_b;
    logic                  lane_eq;
    logic                  lane_lt;
    logic [PW-1:0]         pop;
    logic [SW-1:0]         cnt_sum;
    logic [CNT_W-1:0]      cnt_next;

    // Stage 2 advances when it is empty or its beat is leaving this cycle;
    // stage 1 can take a new beat when it is empty or draining into stage 2.
    assign s2_load  = s1_valid & (~out_valid | out_ready);
    assign in_ready = ready_en & ~rst & (~s1_valid | s2_load);
    assign s1_load  = in_valid & in_ready;

`ifdef STREAM_COMPARATOR_SIGNED_EN
    // Stage 1 capture of operands, op code and compare mode for each beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_op     <= '0;
            s1_signed <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (s1_load) begin
                s1_valid  <= 1'b1;
                s1_a      <= a;
                s1_b      <= b;
                s1_op     <= op;
                s1_signed <= signed_mode;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
    assign s1_signed = 1'b0;

    // Stage 1 capture of operands and op code; mode input is ignored here.
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_en <= 1'b0;
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else begin
            ready_en <= 1'b1;
            if (s1_load) begin
                s1_valid <= 1'b1;
                s1_a     <= a;
                s1_b     <= b;
                s1_op    <= op;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
        end
    end
`endif

    // Per-lane relation; a signed compare is an unsigned compare with both
    // sign bits inverted, and reserved op codes yield zero.
    always_comb begin
        cmp     = '0;
        lane_a  = '0;
        lane_b  = '0;
        lane_eq = 1'b0;
        lane_lt = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            lane_a = s1_a[i*BITS +: BITS];
            lane_b = s1_b[i*BITS +: BITS];
            if (s1_signed) begin
                lane_a[BITS-1] = ~lane_a[BITS-1];
                lane_b[BITS-1] = ~lane_b[BITS-1];
            end
            lane_eq = (lane_a == lane_b);
            lane_lt = (lane_a < lane_b);
            case (s1_op)
                OP_EQ:   cmp[i] = lane_eq;
                OP_NEQ:  cmp[i] = ~lane_eq;
                OP_LT:   cmp[i] = lane_lt;
                OP_LTE:  cmp[i] = lane_lt | lane_eq;
                OP_GT:   cmp[i] = ~(lane_lt | lane_eq);
                OP_GTE:  cmp[i] = ~lane_lt;
                default: cmp[i] = 1'b0;
            endcase
        end
    end

    // Stage 2 holds the result until downstream accepts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            any_match <= 1'b0;
            all_match <= 1'b0;
        end else if (s2_load) begin
            out_valid <= 1'b1;
            result    <= cmp;
            any_match <= |cmp;
            all_match <= &cmp;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Popcount of the presented result and the saturated next count.
    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) begin
            pop = pop + PW'(result[i]);
        end
        cnt_sum = {1'b0, match_cnt} + SW'(pop);
        if (cnt_sum[CNT_W]) begin
            cnt_next = '1;
        end else begin
            cnt_next = cnt_sum[CNT_W-1:0];
        end
    end

    // Match counter: clear beats an output transfer in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_cnt <= '0;
        end else if (clear) begin
            match_cnt <= '0;
        end else if (out_valid && out_ready) begin
            match_cnt <= cnt_next;
        end
    end

endmodule
